// File: rtl/dcache_write_buffer.sv
// Single-entry write buffer between the data cache and the memory arbiter.
// Evicted lines are parked here and drained in the background; reads snoop the parked line.
module dcache_write_buffer #(
  parameter int OFFSET_BITS = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  c_address,
  input  logic [255:0] c_wdata,
  input  logic         c_read,
  input  logic         c_write,
  output logic [255:0] c_rdata,
  output logic         c_resp,
  output logic [31:0]  m_address,
  output logic [255:0] m_wdata,
  output logic         m_read,
  output logic         m_write,
  input  logic [255:0] m_rdata,
  input  logic         m_resp,
  output logic         buf_valid
);

  localparam int TAG_W = 32 - OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_HIT = 3'd1,
    RD_MEM = 3'd2,
    WR_ACK = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t             state_reg;
  logic [TAG_W-1:0]   buf_tag_reg;
  logic [255:0]       buf_data_reg;
  logic               buf_valid_reg;
  logic               line_match;

  assign line_match = buf_valid_reg && (c_address[31:OFFSET_BITS] == buf_tag_reg);
  assign buf_valid  = buf_valid_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      buf_tag_reg   <= '0;
      buf_data_reg  <= '0;
      buf_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Reads win over writes; a pending drain only runs when the cache is quiet.
          if (c_read) begin
            state_reg <= line_match ? RD_HIT : RD_MEM;
          end else if (c_write) begin
            if (!buf_valid_reg || line_match) begin
              buf_tag_reg   <= c_address[31:OFFSET_BITS];
              buf_data_reg  <= c_wdata;
              buf_valid_reg <= 1'b1;
              state_reg     <= WR_ACK;
            end else begin
              state_reg <= DRAIN;
            end
          end else if (buf_valid_reg) begin
            state_reg <= DRAIN;
          end
        end
        RD_HIT, WR_ACK: state_reg <= IDLE;
        RD_MEM: begin
          if (m_resp) state_reg <= IDLE;
        end
        DRAIN: begin
          if (m_resp) begin
            buf_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state; RD_MEM forwards the arbiter response untouched.
  always_comb begin
    c_rdata   = '0;
    c_resp    = 1'b0;
    m_address = '0;
    m_wdata   = '0;
    m_read    = 1'b0;
    m_write   = 1'b0;
    case (state_reg)
      RD_HIT: begin
        c_rdata = buf_data_reg;
        c_resp  = 1'b1;
      end
      RD_MEM: begin
        m_read    = 1'b1;
        m_address = c_address;
        c_rdata   = m_rdata;
        c_resp    = m_resp;
      end
      WR_ACK: c_resp = 1'b1;
      DRAIN: begin
        m_write   = 1'b1;
        m_address = {buf_tag_reg, {OFFSET_BITS{1'b0}}};
        m_wdata   = buf_data_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: directed scenarios then random traffic
// checked against a one-entry buffer model and a latency-randomised memory responder.
module tb_dcache_write_buffer;

  localparam int OB = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  c_address;
  logic [255:0] c_wdata;
  logic         c_read, c_write;
  logic [255:0] c_rdata;
  logic         c_resp;
  logic [31:0]  m_address;
  logic [255:0] m_wdata;
  logic         m_read, m_write;
  logic [255:0] m_rdata;
  logic         m_resp;
  logic         buf_valid;

  dcache_write_buffer #(.OFFSET_BITS(OB)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_address(c_address), .c_wdata(c_wdata), .c_read(c_read), .c_write(c_write),
    .c_rdata(c_rdata), .c_resp(c_resp),
    .m_address(m_address), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata), .m_resp(m_resp), .buf_valid(buf_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the single parked line
  logic             mv;
  logic [31-OB:0]   mtag;
  logic [255:0]     mdata;

  int           lat, busy;
  logic         prev_cresp;
  logic         saw_mread, saw_mwrite, saw_drain, saw_resp, resp_with_mresp;
  logic [255:0] got_rdata, mem_rdata;
  logic [31:0]  cur_addr;
  logic [255:0] d1, d2, d3;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive cache inputs, answer the memory side, sample at the falling edge.
  task automatic cycle(input logic rd, input logic wr, input logic [31:0] addr, input logic [255:0] data);
    @(posedge clk);
    #1;
    c_read = rd; c_write = wr; c_address = addr; c_wdata = data;
    if (m_read || m_write) begin
      busy++;
      if (m_read) m_rdata = rand256();
      m_resp = (busy >= lat);
      if (m_resp) begin
        busy = 0;
        lat = $urandom_range(1, 4);
      end
    end else begin
      m_resp = 1'b0;
      busy = 0;
    end
    @(negedge clk);
    chk("m_rw_exclusive", m_read && m_write, 0);
    chk("c_resp_b2b", c_resp && prev_cresp, 0);
    if (!m_read && !m_write) begin
      chk("m_addr_idle", m_address, 0);
      chk("m_wdata_idle", m_wdata, 0);
    end
    if (m_read) begin
      chk("rd_mem_addr", m_address, cur_addr);
      saw_mread = 1'b1;
    end
    if (m_write) saw_mwrite = 1'b1;
    if (m_write && m_resp) begin
      chk("drain_valid", mv, 1);
      chk("drain_addr", m_address, {mtag, {OB{1'b0}}});
      chk("drain_data", m_wdata, mdata);
      $display("[TB] drain addr=%08h", m_address);
      mv = 1'b0;
      saw_drain = 1'b1;
    end
    if (c_resp) begin
      saw_resp = 1'b1;
      got_rdata = c_rdata;
      resp_with_mresp = m_resp;
      mem_rdata = m_rdata;
    end
    prev_cresp = c_resp;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] data, output logic drained);
    logic need_drain;
    int n;
    need_drain = mv && (addr[31:OB] != mtag);
    saw_drain = 0; saw_resp = 0; n = 0;
    cur_addr = addr;
    while (!saw_resp && n < 40) begin
      cycle(1'b0, 1'b1, addr, data);
      n++;
    end
    chk("wr_resp_timeout", saw_resp, 1);
    if (need_drain) chk("wr_drain_first", saw_drain, 1);
    if (!saw_drain) chk("wr_latency", n, 2);
    mv = 1'b1; mtag = addr[31:OB]; mdata = data;
    chk("wr_buf_valid", buf_valid, 1);
    drained = saw_drain;
    $display("[TB] write addr=%08h cycles=%0d drained=%0d", addr, n, saw_drain);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic drained);
    logic exp_hit;
    int n;
    saw_mread = 0; saw_drain = 0; saw_resp = 0; n = 0;
    cur_addr = addr;
    while (!saw_resp && n < 40) begin
      cycle(1'b1, 1'b0, addr, '0);
      n++;
    end
    chk("rd_resp_timeout", saw_resp, 1);
    exp_hit = mv && (addr[31:OB] == mtag);
    chk("rd_path_mem", saw_mread, !exp_hit);
    if (exp_hit) begin
      chk("rd_hit_data", got_rdata, mdata);
      if (!saw_drain) chk("rd_hit_latency", n, 2);
    end else begin
      chk("rd_miss_data", got_rdata, mem_rdata);
      chk("rd_resp_with_mresp", resp_with_mresp, 1);
    end
    chk("rd_buf_valid", buf_valid, mv);
    drained = saw_drain;
    $display("[TB] read addr=%08h cycles=%0d hit=%0d", addr, n, exp_hit);
  endtask

  task automatic drain_wait();
    int k;
    saw_drain = 0; k = 0;
    while (!saw_drain && k < 20) begin
      cycle(1'b0, 1'b0, '0, '0);
      k++;
    end
    chk("drain_seen", saw_drain, 1);
  endtask

  initial begin
    logic dr;
    int k;
    reset_n = 1'b1;
    c_read = 0; c_write = 0; c_address = '0; c_wdata = '0;
    m_rdata = '0; m_resp = 0;
    mv = 0; mtag = '0; mdata = '0;
    busy = 0; lat = 2; prev_cresp = 0;
    saw_mread = 0; saw_mwrite = 0; saw_drain = 0; saw_resp = 0; resp_with_mresp = 0;
    got_rdata = '0; mem_rdata = '0; cur_addr = '0;
    d1 = rand256(); d2 = rand256(); d3 = rand256();

    // Reset takes effect before any clock edge
    #1 reset_n = 1'b0;
    #2;
    chk("rst_buf_valid", buf_valid, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_c_resp", c_resp, 0);
    chk("rst_m_address", m_address, 0);
    chk("rst_c_rdata", c_rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Capture into empty buffer, then background drain
    do_write(32'h0000_1040, d1, dr);
    drain_wait();
    cycle(1'b0, 1'b0, '0, '0);
    chk("drained_buf_valid", buf_valid, 0);

    // Read hit on parked line at a different offset
    do_write(32'h0000_1040, d1, dr);
    do_read(32'h0000_105C, dr);

    // Read miss goes to memory before the drain
    do_read(32'h0000_2000, dr);
    chk("miss_before_drain", dr, 0);
    drain_wait();

    // Conflicting write drains D1 first
    do_write(32'h0000_1040, d1, dr);
    do_write(32'h0000_3000, d2, dr);
    chk("conflict_drained", dr, 1);

    // Same-line overwrite: no drain, later drain carries D3
    do_write(32'h0000_1040, d1, dr);
    do_write(32'h0000_1040, d3, dr);
    chk("overwrite_no_drain", dr, 0);
    drain_wait();

    // Reset mid-drain
    do_write(32'h0000_1040, d1, dr);
    saw_mwrite = 0; k = 0;
    while (!saw_mwrite && k < 10) begin
      cycle(1'b0, 1'b0, '0, '0);
      k++;
    end
    chk("drain_started", saw_mwrite, 1);
    #2 reset_n = 1'b0;
    m_resp = 1'b0;
    #1;
    chk("rst_mid_m_write", m_write, 0);
    chk("rst_mid_buf_valid", buf_valid, 0);
    chk("rst_mid_m_address", m_address, 0);
    mv = 0; busy = 0; prev_cresp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    saw_mread = 0; saw_mwrite = 0;
    repeat (6) cycle(1'b0, 1'b0, '0, '0);
    chk("post_rst_quiet", saw_mread || saw_mwrite, 0);
    chk("post_rst_buf_valid", buf_valid, 0);
    $display("[TB] reset mid-drain done");

    // Random traffic over a small tag pool so hits and conflicts both occur
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) cycle(1'b0, 1'b0, '0, '0);
      a = 32'h0000_1000 + ($urandom_range(0, 3) << OB) + $urandom_range(0, 31);
      if ($urandom_range(0, 9) < 5) do_read(a, dr);
      else do_write(a, rand256(), dr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
